// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of the Hack memory bus
// One single-word transaction at a time: IDLE -> ACCESS -> ACK -> IDLE.
module mem_arbiter #(
  parameter int READ_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        a_req,
  input  logic [14:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic        a_we,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic [14:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic        b_we,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic [14:0] mem_address,
  output logic [15:0] mem_dataIn,
  output logic        mem_load,
  input  logic [15:0] mem_dataOut
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  localparam int CW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(READ_LATENCY);

  logic [1:0]    state;
  logic          owner;       // 0 = port A, 1 = port B
  logic          last_grant;  // same encoding as owner
  logic          we_q;
  logic [CW-1:0] cnt;
  logic          any_req;
  logic          grant_b;

  // On a tie, the port that was not granted last time wins.
  always_comb begin
    any_req = a_req | b_req;
    grant_b = b_req & (~a_req | ~last_grant);
  end

  assign mem_load = (state == S_ACCESS) && we_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      we_q        <= 1'b0;
      cnt         <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      mem_address <= '0;
      mem_dataIn  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          if (any_req) begin
            owner       <= grant_b;
            last_grant  <= grant_b;
            mem_address <= grant_b ? b_addr  : a_addr;
            mem_dataIn  <= grant_b ? b_wdata : a_wdata;
            we_q        <= grant_b ? b_we    : a_we;
            cnt         <= CNT_INIT;
            state       <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (we_q || cnt == '0) begin
            a_ack <= ~owner;
            b_ack <= owner;
            if (!we_q) begin
              if (owner) b_rdata <= mem_dataOut;
              else       a_rdata <= mem_dataOut;
            end
            state <= S_ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_ACK: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
